wb_master_ctrl: RTL and testbench
=================================

# wb_master_ctrl

Single-outstanding Wishbone B4 pipelined bus master. It turns one-word read and write commands from a local request port into Wishbone bus cycles, and returns read data or error status on a response port. It drives the bus from the initiator end, facing the register-file slave and its protocol checkers. A watchdog terminates cycles the slave never completes.

## Interface
- ADDR_WIDTH, 16, address width
- DATA_WIDTH, 32, data width
- GRANULE, 8, bits per select lane
- SEL_WIDTH, DATA_WIDTH/GRANULE (localparam), select width
- TIMEOUT, 255, maximum cycles from issue to completion before abort; must be ≥ 2

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at an edge
- cmd_we  in  1  1 = write, 0 = read
- cmd_adr  in  ADDR_WIDTH  word address
- cmd_dat  in  DATA_WIDTH  write data
- cmd_sel  in  SEL_WIDTH  byte-lane select
- rsp_valid  out  1  one-cycle completion pulse
- rsp_dat  out  DATA_WIDTH  read data; 0 for writes and errors
- rsp_err  out  1  completion was err_i or timeout
- rsp_timeout  out  1  completion was timeout
- cyc_o, stb_o, we_o  out  1  Wishbone cycle, strobe, write enable
- adr_o  out  ADDR_WIDTH  Wishbone address
- dat_o  out  DATA_WIDTH  Wishbone write data
- sel_o  out  SEL_WIDTH  Wishbone select
- dat_i  in  DATA_WIDTH  Wishbone read data
- ack_i, err_i, stall_i  in  1  Wishbone acknowledge, error, stall

## Operation
- States: IDLE, REQ (cyc_o=stb_o=1, waiting for stall_i=0), WAIT (cyc_o=1, stb_o=0, waiting for ack_i/err_i).
- cmd_ready = (state==IDLE), combinational from state only.
- Command accept:
  - Registers we_o, adr_o, dat_o, sel_o.
  - Goes to REQ and clears the timeout counter.
  - Bus outputs hold stable until completion.
- REQ, edge with stall_i=1: stay in REQ. ack_i/err_i are ignored because the request is not yet accepted.
- REQ, edge with stall_i=0:
  - If ack_i or err_i is also high, the cycle completes.
  - Otherwise go to WAIT.
- WAIT, edge with ack_i or err_i: the cycle completes.
- Completion:
  - Next cycle: state=IDLE, cyc_o=stb_o=0, rsp_valid=1 for exactly one cycle.
  - ack_i only: rsp_err=0; rsp_dat = dat_i if read, else 0.
  - err_i (with or without ack_i): rsp_err=1, rsp_dat=0. Simultaneous ack/err is treated as error.
- Timeout:
  - The counter increments every cycle in REQ or WAIT.
  - At an edge where counter == TIMEOUT−1 and no completion condition holds, abort: next cycle cyc_o=stb_o=0, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_dat=0.
  - A completion condition on that same edge wins over the timeout.
- ack_i/err_i while cyc_o=0 are ignored.
- Outside the rsp_valid cycle, rsp_err, rsp_timeout and rsp_dat read 0.
- we_o, adr_o, dat_o, sel_o keep their last values after completion. They are only meaningful while cyc_o=1.

## Timing
- Reset values (asserted asynchronously when rst_i=0):
  - cyc_o=0, stb_o=0, we_o=0, adr_o=0, dat_o=0, sel_o=0.
  - rsp_valid=0, rsp_dat=0, rsp_err=0, rsp_timeout=0.
  - state=IDLE, so cmd_ready=1.
- Reset mid-transaction: bus is released immediately; no response is produced.
- Latency: command accepted at edge E0 → cyc_o/stb_o high from E0 until the edge after acceptance.
- Zero-stall slave acking one cycle after the strobe: cyc_o high 2 cycles, stb_o high 1 cycle, rsp_valid in the 3rd cycle after E0.
- Back-to-back:
  - cmd_ready=1 in the rsp_valid cycle, so a new command may be accepted then.
  - cyc_o is low for exactly one cycle between consecutive transactions.
- Timeout: rsp_valid appears TIMEOUT cycles after cyc_o first rises.

## Test plan
- Write adr=0x0004, dat=0xDEADBEEF, sel=0xF, slave stall=0, ack 1 cycle later → one stb_o cycle with we_o=1 and those values; rsp_valid=1, rsp_err=0, rsp_dat=0.
- Read adr=0x0008, slave holds stall_i=1 for 3 cycles then acks with dat_i=0x12345678 → stb_o high 4 cycles, adr_o stable; rsp_dat=0x12345678, rsp_err=0.
- Read answered with err_i=1 (also ack_i=1 simultaneously in a second run) → rsp_valid=1, rsp_err=1, rsp_timeout=0, rsp_dat=0.
- TIMEOUT=8, slave never acks → cyc_o high exactly 8 cycles, then rsp_valid=1, rsp_err=1, rsp_timeout=1. A stray ack_i in the next cycle is ignored.
- cmd_valid held high with 3 queued reads → cmd_ready pulses once per transaction, one idle cyc_o cycle between transactions, three rsp_valid pulses in order.
- rst_i driven low while in WAIT → cyc_o/stb_o drop without waiting for a clock edge, no rsp_valid; after release, cmd_ready=1 and the next command proceeds normally.

Source files
------------

// File: rtl/wb_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : wb_master_ctrl
// Brief    : Single-outstanding Wishbone B4 pipelined master with a watchdog
//            that aborts bus cycles the slave never completes.
// Revision : 1.0 - initial release
// ============================================================================
module wb_master_ctrl #(
    parameter  int ADDR_WIDTH = 16,
    parameter  int DATA_WIDTH = 32,
    parameter  int GRANULE    = 8,
    parameter  int TIMEOUT    = 255,
    localparam int SEL_WIDTH  = DATA_WIDTH / GRANULE
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    // local command / response port
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_adr,
    input  logic [DATA_WIDTH-1:0] cmd_dat,
    input  logic [SEL_WIDTH-1:0]  cmd_sel,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_dat,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    // Wishbone master port
    output logic                  cyc_o,
    output logic                  stb_o,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] adr_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic [SEL_WIDTH-1:0]  sel_o,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic                  ack_i,
    input  logic                  err_i,
    input  logic                  stall_i
);

    localparam int                   CNT_WIDTH = $clog2(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_tmo_cnt;

    logic w_active;
    logic w_taken;
    logic w_done;
    logic w_abort;

    assign cmd_ready = (r_state == ST_IDLE);
    assign w_active  = (r_state == ST_REQ) || (r_state == ST_WAIT);

    // A termination only counts once the slave has taken the strobe; while
    // stalled in REQ any ack/err belongs to nothing we issued.
    assign w_taken   = (r_state == ST_WAIT) || !stall_i;
    assign w_done    = w_active && w_taken && (ack_i || err_i);
    assign w_abort   = w_active && !w_done && (r_tmo_cnt == CNT_LAST);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= ST_IDLE;
            r_tmo_cnt   <= '0;
            cyc_o       <= 1'b0;
            stb_o       <= 1'b0;
            we_o        <= 1'b0;
            adr_o       <= '0;
            dat_o       <= '0;
            sel_o       <= '0;
            rsp_valid   <= 1'b0;
            rsp_dat     <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid   <= 1'b0;
            rsp_dat     <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        we_o      <= cmd_we;
                        adr_o     <= cmd_adr;
                        dat_o     <= cmd_dat;
                        sel_o     <= cmd_sel;
                        cyc_o     <= 1'b1;
                        stb_o     <= 1'b1;
                        r_tmo_cnt <= '0;
                        r_state   <= ST_REQ;
                    end
                end

                ST_REQ, ST_WAIT: begin
                    r_tmo_cnt <= r_tmo_cnt + CNT_WIDTH'(1);
                    if (w_done) begin
                        cyc_o     <= 1'b0;
                        stb_o     <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= err_i;
                        rsp_dat   <= (!err_i && !we_o) ? dat_i : '0;
                        r_state   <= ST_IDLE;
                    end else if (w_abort) begin
                        cyc_o       <= 1'b0;
                        stb_o       <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else if ((r_state == ST_REQ) && !stall_i) begin
                        stb_o   <= 1'b0;
                        r_state <= ST_WAIT;
                    end
                end

                default: begin
                    cyc_o   <= 1'b0;
                    stb_o   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_master_ctrl
// Brief    : Scoreboard bench for wb_master_ctrl with a scripted slave and a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_master_ctrl;

    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int SW  = 4;
    localparam int TMO = 8;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [AW-1:0] cmd_adr = '0;
    logic [DW-1:0] cmd_dat = '0;
    logic [SW-1:0] cmd_sel = '0;
    logic          rsp_valid, rsp_err, rsp_timeout;
    logic [DW-1:0] rsp_dat;
    logic          cyc_o, stb_o, we_o;
    logic [AW-1:0] adr_o;
    logic [DW-1:0] dat_o;
    logic [SW-1:0] sel_o;
    logic [DW-1:0] dat_i = '0;
    logic          ack_i = 1'b0, err_i = 1'b0, stall_i = 1'b0;

    wb_master_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GRANULE(8), .TIMEOUT(TMO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o),
        .dat_o(dat_o), .sel_o(sel_o), .dat_i(dat_i),
        .ack_i(ack_i), .err_i(err_i), .stall_i(stall_i)
    );

    always #5 clk_i = ~clk_i;

    // kind: 0 = ack, 1 = err, 2 = ack+err together, 3 = slave never answers
    typedef struct {
        bit            we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic [SW-1:0] sel;
        int            stall;
        int            delay;
        int            kind;
        logic [DW-1:0] rdata;
    } plan_t;

    typedef struct {
        logic [DW-1:0] dat;
        bit            err;
        bit            tmo;
        int            lat;
        int            t0;
    } exp_t;

    plan_t plan_q[$];
    exp_t  exp_q[$];
    int    errors = 0;
    int    checks = 0;
    int    cycle  = 0;

    always @(posedge clk_i) cycle <= cycle + 1;

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    // Response predicted from the slave's script: the slave terminates on
    // edge stall+1+delay after acceptance; past TIMEOUT edges the master aborts.
    function automatic exp_t model(plan_t p);
        exp_t e;
        int   done_at = p.stall + 1 + p.delay;
        e.t0 = 0;
        if (p.kind == 3 || done_at > TMO) begin
            e.dat = '0; e.err = 1'b1; e.tmo = 1'b1; e.lat = TMO;
        end else begin
            e.lat = done_at;
            e.tmo = 1'b0;
            e.err = (p.kind != 0);
            e.dat = (p.kind == 0 && !p.we) ? p.rdata : '0;
        end
        return e;
    endfunction

    function automatic plan_t mk(bit we, logic [AW-1:0] adr, logic [DW-1:0] dat,
                                 logic [SW-1:0] sel, int s, int d, int kind,
                                 logic [DW-1:0] rd);
        plan_t p;
        p.we = we; p.adr = adr; p.dat = dat; p.sel = sel;
        p.stall = s; p.delay = d; p.kind = kind; p.rdata = rd;
        return p;
    endfunction

    function automatic plan_t rand_plan();
        int    r1 = $urandom_range(0, 9);
        int    r2 = $urandom_range(0, 9);
        int    r3 = $urandom_range(0, 9);
        int    kind;
        kind = (r3 < 6) ? 0 : (r3 < 8) ? 1 : (r3 == 8) ? 2 : 3;
        return mk(1'($urandom), AW'($urandom), $urandom, SW'($urandom),
                  (r1 < 7) ? $urandom_range(0, 2) : $urandom_range(3, 9),
                  (r2 < 7) ? $urandom_range(0, 2) : $urandom_range(3, 9),
                  kind, $urandom);
    endfunction

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(plan_t p);
        int   w = 0;
        exp_t e;
        cmd_valid = 1'b1; cmd_we = p.we; cmd_adr = p.adr;
        cmd_dat = p.dat; cmd_sel = p.sel;
        while (!cmd_ready && w < 200) begin
            @(negedge clk_i);
            w++;
        end
        if (!cmd_ready) begin
            checks++; errors++;
            $display("FAIL cmd_ready_wait: got 0 expected 1 within 200 cycles");
            finish_run();
        end
        @(posedge clk_i);
        #1;
        e    = model(p);
        e.t0 = cycle;
        plan_q.push_back(p);
        exp_q.push_back(e);
        @(negedge clk_i);
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(negedge clk_i);
            w++;
        end
        check("drain_pending", 64'(exp_q.size()), 64'(0));
    endtask

    // Scripted slave: follows the plan of the cycle in flight, drives noise
    // on ack/err whenever the master must ignore them.
    plan_t sp;
    bit    s_active = 1'b0;
    int    k = 0;
    bit    hit;

    always @(negedge clk_i) begin
        if (!rst_i || !cyc_o) begin
            s_active = 1'b0;
            stall_i  = 1'($urandom);
            ack_i    = 1'($urandom);
            err_i    = 1'($urandom);
            dat_i    = $urandom;
        end else begin
            if (!s_active) begin
                if (plan_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_cycle: got cyc_o=1 expected no cycle");
                    sp = mk(1'b0, '0, '0, '0, 0, 0, 0, '0);
                end else begin
                    sp = plan_q.pop_front();
                end
                s_active = 1'b1;
                k = 1;
            end else begin
                k++;
            end
            check("stb_o", 64'(stb_o), 64'(k <= sp.stall + 1));
            check("we_o",  64'(we_o),  64'(sp.we));
            check("adr_o", 64'(adr_o), 64'(sp.adr));
            check("dat_o", 64'(dat_o), 64'(sp.dat));
            check("sel_o", 64'(sel_o), 64'(sp.sel));

            hit = (sp.kind != 3) && (k == sp.stall + 1 + sp.delay);
            if (k <= sp.stall) begin
                stall_i = 1'b1;
                ack_i   = 1'($urandom);
                err_i   = 1'($urandom);
            end else begin
                stall_i = (k == sp.stall + 1) ? 1'b0 : 1'($urandom);
                ack_i   = hit && (sp.kind == 0 || sp.kind == 2);
                err_i   = hit && (sp.kind == 1 || sp.kind == 2);
            end
            dat_i = hit ? sp.rdata : $urandom;
        end
    end

    // Response monitor
    exp_t me;
    always @(negedge clk_i) begin
        if (rst_i) begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 expected 0");
                end else begin
                    me = exp_q.pop_front();
                    check("rsp_dat",     64'(rsp_dat),     64'(me.dat));
                    check("rsp_err",     64'(rsp_err),     64'(me.err));
                    check("rsp_timeout", 64'(rsp_timeout), 64'(me.tmo));
                    check("rsp_latency", 64'(cycle - me.t0), 64'(me.lat));
                    check("rsp_cyc_low", 64'(cyc_o),       64'(0));
                    check("rsp_ready",   64'(cmd_ready),   64'(1));
                end
            end else begin
                check("idle_rsp_zero", 64'({rsp_err, rsp_timeout, rsp_dat}), 64'(0));
            end
        end
    end

    initial begin
        #500000;
        checks++; errors++;
        $display("FAIL global_watchdog: got timeout expected completion");
        finish_run();
    end

    initial begin
        #3;
        check("rst_cyc",   64'(cyc_o),     64'(0));
        check("rst_stb",   64'(stb_o),     64'(0));
        check("rst_bus",   64'({we_o, adr_o, dat_o, sel_o}), 64'(0));
        check("rst_rsp",   64'({rsp_valid, rsp_err, rsp_timeout, rsp_dat}), 64'(0));
        check("rst_ready", 64'(cmd_ready), 64'(1));
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);

        send(mk(1'b1, 16'h0004, 32'hDEADBEEF, 4'hF, 0, 1, 0, 32'h0));
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk_i);
        send(mk(1'b0, 16'h0008, 32'h0, 4'hF, 3, 0, 0, 32'h12345678));
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk_i);
        send(mk(1'b0, 16'h0010, 32'h0, 4'hF, 0, 1, 1, 32'hCAFEF00D));
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk_i);
        send(mk(1'b0, 16'h0014, 32'h0, 4'h3, 1, 0, 2, 32'hCAFEF00D));
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk_i);
        send(mk(1'b0, 16'h0018, 32'h0, 4'hF, 0, 0, 3, 32'h0));
        cmd_valid = 1'b0;
        drain();

        for (int i = 0; i < 3; i++)
            send(mk(1'b0, AW'(16'h0100 + 4 * i), 32'h0, 4'hF, i, 1, 0, 32'hA0000000 + i));
        cmd_valid = 1'b0;
        drain();

        for (int i = 0; i < 200; i++) begin
            send(rand_plan());
            if ($urandom_range(0, 2) == 0) begin
                cmd_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk_i);
            end
        end
        cmd_valid = 1'b0;
        drain();

        // Reset while the master sits in WAIT
        send(mk(1'b0, 16'h00AA, 32'h0, 4'hF, 0, 0, 3, 32'h0));
        cmd_valid = 1'b0;
        @(negedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        check("mid_rst_cyc",   64'(cyc_o),     64'(0));
        check("mid_rst_stb",   64'(stb_o),     64'(0));
        check("mid_rst_rsp",   64'(rsp_valid), 64'(0));
        check("mid_rst_ready", 64'(cmd_ready), 64'(1));
        exp_q.delete();
        repeat (2) begin
            @(negedge clk_i);
            check("in_rst_rsp", 64'(rsp_valid), 64'(0));
        end
        rst_i = 1'b1;
        @(negedge clk_i);
        check("post_rst_ready", 64'(cmd_ready), 64'(1));
        send(mk(1'b0, 16'h00AC, 32'h0, 4'hF, 1, 1, 0, 32'h5A5A1234));
        cmd_valid = 1'b0;
        drain();
        repeat (3) @(negedge clk_i);
        finish_run();
    end

endmodule
`default_nettype wire
